// File: rtl/crg_pkg.sv
// Shared types and helpers for the clock/reset generation blocks.
package crg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        GAP,
        WAIT_ACK,
        DONE,
        ERROR
    } rst_seq_state_e;

    // Bits needed to count up to the larger of two cycle limits, inclusive.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Releases NUM_RST domain resets in index order, waiting for each domain's
// ack and a fixed gap between releases; supports timeout and re-sequence.
module rst_release_seq
    import crg_pkg::*;
#(
    parameter int unsigned NUM_RST     = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 64,
    localparam int unsigned SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               start_i,
    input  logic               sw_rst_req_i,
    input  logic [NUM_RST-1:0] rst_ack_i,
    output logic [NUM_RST-1:0] rst_no,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [SW-1:0]      stage_o
);

    localparam int unsigned    CW       = cnt_width(GAP_CYCLES, ACK_TIMEOUT);
    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'((ACK_TIMEOUT == 0) ? 32'd0 : ACK_TIMEOUT - 1);
    localparam logic [SW-1:0]  IDX_LAST = SW'(NUM_RST - 1);

    rst_seq_state_e     state_q, state_d;
    logic [SW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [NUM_RST-1:0] rst_q, rst_d;
    logic               busy_q, done_q, err_q;
    logic [NUM_RST-1:0] ack_s;

    for (genvar i = 0; i < NUM_RST; i++) begin : g_sync
        sync_bit #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .arst_ni(arst_ni),
            .d_i    (rst_ack_i[i]),
            .q_o    (ack_s[i])
        );
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        if (state_q != IDLE && !start_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            rst_d   = '0;
        end else if (state_q != IDLE && sw_rst_req_i) begin
            state_d = HOLD;
            idx_d   = '0;
            cnt_d   = '0;
            rst_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = GAP;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_d[idx_q] = 1'b1;
                        state_d      = WAIT_ACK;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_ACK: begin
                    // An ack arriving on the timeout cycle still counts as success.
                    if (ack_s[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                            rst_d   = '1;
                        end else begin
                            state_d = GAP;
                            idx_d   = idx_q + SW'(1);
                        end
                    end else if (ACK_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            busy_q  <= (state_d == HOLD) || (state_d == GAP) || (state_d == WAIT_ACK);
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == ERROR);
        end
    end

    assign rst_no  = rst_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign stage_o = idx_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed self-checking bench for rst_release_seq with default parameters.
module tb_rst_release_seq;

    logic       clk = 1'b0;
    logic       arst_ni = 1'b1;
    logic       start = 1'b0;
    logic       sw = 1'b0;
    logic [3:0] mask = 4'b1111;
    logic [3:0] rst_ack;
    logic [3:0] rst_no;
    logic       busy, done, err;
    logic [1:0] stage;
    logic [8:0] got, exp;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    assign rst_ack = rst_no & mask;
    assign got     = {rst_no, busy, done, err, stage};

    rst_release_seq dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .start_i     (start),
        .sw_rst_req_i(sw),
        .rst_ack_i   (rst_ack),
        .rst_no      (rst_no),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .stage_o     (stage)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected {rst_no, busy, done, err, stage} t edges after the edge that enters GAP for stage 0.
    function automatic logic [8:0] exp_seq(input int t);
        logic [3:0] r;
        logic [1:0] s;
        for (int i = 0; i < 4; i++) r[i] = (t >= 16 + 19 * i);
        s = (t >= 57) ? 2'd3 : (t >= 38) ? 2'd2 : (t >= 19) ? 2'd1 : 2'd0;
        return {r, (t < 76), (t >= 76), 1'b0, s};
    endfunction

    // Same, but starting from entry into HOLD (16 cycles of hold first).
    function automatic logic [8:0] exp_hold(input int t);
        if (t < 16) return {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
        return exp_seq(t - 16);
    endfunction

    task automatic do_reset();
        start = 1'b0;
        sw    = 1'b0;
        mask  = 4'b1111;
        @(posedge clk);
        #1 arst_ni = 1'b0;
        tick(2);
        arst_ni = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        #1 arst_ni = 1'b0;
        #2;
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL reset_assert got=%b expected=%b", got, 9'd0);
        end
        tick(2);
        arst_ni = 1'b1;
        tick(3);
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle got=%b expected=%b", got, 9'd0);
        end
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        tick(1);
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL idle_ignores_sw got=%b expected=%b", got, 9'd0);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        start = 1'b1;
        tick(1);
        for (int t = 0; t <= 80; t++) begin
            if (t > 0) tick(1);
            exp = exp_seq(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nominal t=%0d got=%b expected=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mask  = 4'b1011;
        start = 1'b1;
        tick(1);
        for (int t = 0; t <= 124; t++) begin
            if (t > 0) tick(1);
            if (t < 54) exp = exp_seq(t);
            else        exp = {4'b0111, (t < 118), 1'b0, (t >= 118), 2'd2};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout t=%0d got=%b expected=%b", t, got, exp);
            end
        end
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        exp = {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL error_sw_clear got=%b expected=%b", got, exp);
        end
    endtask

    task automatic test_sw_reseq();
        do_reset();
        start = 1'b1;
        tick(1);
        tick(80);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        for (int t = 0; t <= 95; t++) begin
            if (t > 0) tick(1);
            exp = exp_hold(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sw_reseq t=%0d got=%b expected=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_start_drop();
        do_reset();
        start = 1'b1;
        tick(1);
        tick(36);
        start = 1'b0;
        tick(1);
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL start_drop got=%b expected=%b", got, 9'd0);
        end
        start = 1'b1;
        tick(1);
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) tick(1);
            exp = exp_seq(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL start_restart t=%0d got=%b expected=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1;
        tick(1);
        tick(45);
        #2 arst_ni = 1'b0;
        #1;
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got=%b expected=%b", got, 9'd0);
        end
        #2 arst_ni = 1'b1;
        tick(1);
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) tick(1);
            exp = exp_seq(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_restart t=%0d got=%b expected=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start = 1'b1;
        tick(1);
        tick(37);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) tick(1);
            exp = exp_hold(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sw_with_ack t=%0d got=%b expected=%b", t, got, exp);
            end
        end
        start = 1'b0;
        sw    = 1'b1;
        tick(1);
        sw = 1'b0;
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL start_low_with_sw got=%b expected=%b", got, 9'd0);
        end
        tick(2);
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL stays_idle got=%b expected=%b", got, 9'd0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_sw_reseq();
        test_start_drop();
        test_async_reset();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
